// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: reset constants, instruction field
// positions and the IF/ID state encoding.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

  typedef enum logic [1:0] {
    PRIME = 2'd0,  // memory has not returned data yet
    RUN   = 2'd1,  // decode sees the memory read data
    HOLD  = 2'd2   // decode sees the hold register
  } fetch_state_t;

  // One decode-stage slot: the instruction word and whether it is real.
  typedef struct packed {
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

endpackage

// File: rtl/ifid_hold_buf.sv
// IF/ID boundary buffer. The instruction memory already registers its
// read data, so in RUN the decode slot is the memory output itself. A hold
// register only captures the slot when decode stalls, and a one-cycle
// squash flag turns the wrong-path word after a taken branch into a bubble.
module ifid_hold_buf
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP = NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] imem_rdata,
  input  logic        stallD,
  input  logic        squash,
  output logic [31:0] instrD,
  output logic        validD
);

  fetch_state_t state_q, state_d;
  ifid_t        hold_q;
  ifid_t        cur;
  logic         squash_q;

  // State, hold register and squash flag; reset discards any hold/squash.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= PRIME;
      hold_q.instr   <= NOP;
      hold_q.valid   <= 1'b0;
      squash_q       <= 1'b0;
    end else begin
      state_q  <= state_d;
      // Squash only applies to the word arriving next cycle; the caller
      // already gates it with ~stallD, so it never lands on a HOLD entry.
      squash_q <= squash;
      // Capture exactly what decode sees now, including a squashed bubble.
      if (state_q == RUN && stallD) hold_q <= cur;
    end
  end

  // Next state and decode-slot source; depends only on registered state
  // and the memory output, except the stall-driven state transition.
  always_comb begin
    state_d   = state_q;
    cur.instr = NOP;
    cur.valid = 1'b0;
    case (state_q)
      PRIME: begin
        state_d = RUN;
      end
      RUN: begin
        if (!squash_q) begin
          cur.instr = imem_rdata;
          cur.valid = 1'b1;
        end
        if (stallD) state_d = HOLD;
      end
      HOLD: begin
        cur = hold_q;
        // The PC was frozen during the stall, so memory is already reading
        // the word that follows the held one.
        if (!stallD) state_d = RUN;
      end
      default: begin
        state_d = PRIME;
      end
    endcase
  end

  assign instrD = cur.instr;
  assign validD = cur.valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID boundary: PC register, synchronous
// instruction memory address, decode-stage instruction, PC+4 and the
// register specifiers the hazard unit needs.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP      = NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        pcsrcD,
  input  logic [31:0] pcbranchD,
  output logic [31:0] imem_addrF,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pcF,
  output logic [31:0] instrD,
  output logic [31:0] pcplus4D,
  output logic        validD,
  output logic [4:0]  rsD,
  output logic [4:0]  rtD
);

  logic [31:0] pc_q;
  logic [31:0] pcplus4_q;
  logic [31:0] pc_inc;

  // Wraps modulo 2^32 by width.
  assign pc_inc = pc_q + 32'd4;

  // PC update: reset, then stall, then taken branch, then sequential.
  always_ff @(posedge clk) begin
    if (reset)       pc_q <= RESET_PC;
    else if (stallF) pc_q <= pc_q;
    else if (pcsrcD) pc_q <= pcbranchD;
    else             pc_q <= pc_inc;
  end

  // PC+4 travels with the word fetched this cycle into decode.
  always_ff @(posedge clk) begin
    if (reset)        pcplus4_q <= 32'd0;
    else if (!stallD) pcplus4_q <= pc_inc;
  end

  ifid_hold_buf #(
    .NOP (NOP)
  ) u_ifid (
    .clk        (clk),
    .reset      (reset),
    .imem_rdata (imem_rdata),
    .stallD     (stallD),
    .squash     (pcsrcD & ~stallD),
    .instrD     (instrD),
    .validD     (validD)
  );

  assign imem_addrF = pc_q;
  assign pcF        = pc_q;
  assign pcplus4D   = pcplus4_q;
  assign rsD        = instrD[RS_MSB:RS_LSB];
  assign rtD        = instrD[RT_MSB:RT_LSB];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed scoreboard bench for fetch_stage. Instruction memory returns the
// word equal to its address, one cycle after the address is presented.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stallF, stallD, pcsrcD;
  logic [31:0] pcbranchD;
  logic [31:0] imem_addrF, imem_rdata;
  logic [31:0] pcF, instrD, pcplus4D;
  logic        validD;
  logic [4:0]  rsD, rtD;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        v;
    logic [31:0] p4;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  // Synchronous instruction memory: data = address.
  always @(posedge clk) imem_rdata <= imem_addrF;

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .stallF     (stallF),
    .stallD     (stallD),
    .pcsrcD     (pcsrcD),
    .pcbranchD  (pcbranchD),
    .imem_addrF (imem_addrF),
    .imem_rdata (imem_rdata),
    .pcF        (pcF),
    .instrD     (instrD),
    .pcplus4D   (pcplus4D),
    .validD     (validD),
    .rsD        (rsD),
    .rtD        (rtD)
  );

  // The hazard unit never splits the two stalls.
  always @(posedge clk) assert (stallF === stallD);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare this cycle's outputs against the queued expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [31:0] ei;
      e  = sb.pop_front();
      ei = e.instr;
      chk("pcF",      pcF,               e.pc);
      chk("imem_addr", imem_addrF,       e.pc);
      chk("instrD",   instrD,            e.instr);
      chk("validD",   {31'd0, validD},   {31'd0, e.v});
      chk("pcplus4D", pcplus4D,          e.p4);
      chk("rsD",      {27'd0, rsD},      {27'd0, ei[25:21]});
      chk("rtD",      {27'd0, rtD},      {27'd0, ei[20:16]});
    end
  end

  // Apply inputs for one cycle and queue the outputs expected in it.
  task automatic cyc(input bit rst, input bit st, input bit br, input logic [31:0] tgt,
                     input logic [31:0] epc, input logic [31:0] ei, input bit ev,
                     input logic [31:0] ep4);
    exp_t e;
    reset = rst; stallF = st; stallD = st; pcsrcD = br; pcbranchD = tgt;
    e.pc = epc; e.instr = ei; e.v = ev; e.p4 = ep4;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; stallF = 1'b0; stallD = 1'b0; pcsrcD = 1'b0; pcbranchD = 32'd0;
    @(posedge clk); #1;
    //   rst st br tgt            pcF            instrD         v  pcplus4D
    // Reset and release
    cyc(1, 0, 0, 32'h0,         32'h0,         32'h0,         0, 32'h0);
    cyc(1, 0, 0, 32'h0,         32'h0,         32'h0,         0, 32'h0);
    cyc(0, 0, 0, 32'h0,         32'h0,         32'h0,         0, 32'h0);
    cyc(0, 0, 0, 32'h0,         32'h4,         32'h0,         1, 32'h4);
    cyc(0, 0, 0, 32'h0,         32'h8,         32'h4,         1, 32'h8);
    cyc(0, 0, 0, 32'h0,         32'hC,         32'h8,         1, 32'hC);
    // Two-cycle stall at pcF=0x10
    cyc(0, 1, 0, 32'h0,         32'h10,        32'hC,         1, 32'h10);
    cyc(0, 1, 0, 32'h0,         32'h10,        32'hC,         1, 32'h10);
    cyc(0, 0, 0, 32'h0,         32'h10,        32'hC,         1, 32'h10);
    // Taken branch to 0x100
    cyc(0, 0, 1, 32'h100,       32'h14,        32'h10,        1, 32'h14);
    cyc(0, 0, 0, 32'h0,         32'h100,       32'h0,         0, 32'h18);
    // Branch under stall, then released with pcsrcD still high
    cyc(0, 1, 1, 32'h200,       32'h104,       32'h100,       1, 32'h104);
    cyc(0, 1, 1, 32'h200,       32'h104,       32'h100,       1, 32'h104);
    cyc(0, 0, 1, 32'h200,       32'h104,       32'h100,       1, 32'h104);
    cyc(0, 0, 0, 32'h0,         32'h200,       32'h0,         0, 32'h108);
    // Squashed bubble that is then stalled stays a bubble
    cyc(0, 0, 1, 32'h0123_4000, 32'h204,       32'h200,       1, 32'h204);
    cyc(0, 1, 0, 32'h0,         32'h0123_4000, 32'h0,         0, 32'h208);
    cyc(0, 0, 0, 32'h0,         32'h0123_4000, 32'h0,         0, 32'h208);
    // Nonzero rs/rt fields, then reset in the middle of HOLD
    cyc(0, 1, 0, 32'h0,         32'h0123_4004, 32'h0123_4000, 1, 32'h0123_4004);
    cyc(1, 1, 0, 32'h0,         32'h0123_4004, 32'h0123_4000, 1, 32'h0123_4004);
    cyc(0, 0, 0, 32'h0,         32'h0,         32'h0,         0, 32'h0);
    // PC wrap past 0xFFFF_FFFC
    cyc(0, 0, 1, 32'hFFFF_FFFC, 32'h4,         32'h0,         1, 32'h4);
    cyc(0, 0, 0, 32'h0,         32'hFFFF_FFFC, 32'h0,         0, 32'h8);
    cyc(0, 0, 0, 32'h0,         32'h0,         32'hFFFF_FFFC, 1, 32'h0);
    cyc(0, 0, 0, 32'h0,         32'h4,         32'h0,         1, 32'h4);
    @(negedge clk); #1;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
